// File: rtl/led_blink_array.sv
// -----------------------------------------------------------------------------
// led_blink_array
//   N-channel LED driver in a single clock domain. Each channel can be held
//   OFF or ON, can blink with its own half-period, or can be PWM-dimmed from
//   one shared free-running PWM counter.
//
//   Optional feature macro: LED_BREATHE_EN
//     When defined, PWM channels "breathe". Their duty moves up by one at every
//     half-period expiry until it reaches full scale, then moves down by one
//     until it reaches zero, and the triangle repeats. When the macro is not
//     defined, the PWM duty stays at the written value and no ramp logic is
//     built.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   en         per-channel enable (a disabled channel is dark and its counter is cleared)
//   sync       1-cycle pulse that realigns the phase of every BLINK channel
//   cfg_valid  config write request
//   cfg_ready  config write accept (rises on the 2nd edge after reset is released)
//   cfg_ch     target channel (values >= CH_NUM are accepted and ignored)
//   cfg_mode   0=OFF 1=ON 2=BLINK 3=PWM
//   cfg_half   blink half-period in clocks, minus 1
//   cfg_duty   PWM duty (or the breathe start value)
//   led        registered LED drive
//   tick       1-cycle pulse on each BLINK toggle and at each PWM period end
// -----------------------------------------------------------------------------
module led_blink_array #(
    parameter int unsigned      CH_NUM   = 4,
    parameter int unsigned      CH_W     = 2,
    parameter int unsigned      CNT_W    = 27,
    parameter int unsigned      PWM_W    = 8,
    parameter logic [CNT_W-1:0] DEF_HALF = 27'd24_999_999
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH_NUM-1:0] en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic [PWM_W-1:0]  cfg_duty,
    output logic [CH_NUM-1:0] led,
    output logic [CH_NUM-1:0] tick
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    localparam logic [PWM_W-1:0] DUTY_RST = {1'b1, {(PWM_W-1){1'b0}}};
    localparam logic [PWM_W-1:0] PWM_MAX  = '1;

    mode_e              mode_q  [CH_NUM];
    mode_e              mode_d  [CH_NUM];
    logic [CNT_W-1:0]   half_q  [CH_NUM];
    logic [CNT_W-1:0]   half_d  [CH_NUM];
    logic [PWM_W-1:0]   duty_q  [CH_NUM];
    logic [PWM_W-1:0]   duty_d  [CH_NUM];
    logic [CNT_W-1:0]   cnt_q   [CH_NUM];
    logic [CNT_W-1:0]   cnt_d   [CH_NUM];
`ifdef LED_BREATHE_EN
    logic               dir_up_q [CH_NUM];
    logic               dir_up_d [CH_NUM];
`endif
    logic [CH_NUM-1:0]  led_q, led_d;
    logic [CH_NUM-1:0]  tick_q, tick_d;
    logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic               ready_pipe_q, ready_pipe_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic [CH_NUM-1:0]  cfg_hit;

    // One-hot decode of the accepted write. A channel number outside
    // 0..CH_NUM-1 matches no channel, so that write is silently dropped.
    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            cfg_hit[i] = cfg_valid && cfg_ready_q && (cfg_ch == CH_W'(i));
        end
    end

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path leaves it unassigned (no latch).
        pwm_cnt_d    = pwm_cnt_q + PWM_W'(1);  // wraps naturally at 2**PWM_W
        ready_pipe_d = 1'b1;
        cfg_ready_d  = ready_pipe_q;
        mode_d       = mode_q;
        half_d       = half_q;
        duty_d       = duty_q;
        cnt_d        = cnt_q;
`ifdef LED_BREATHE_EN
        dir_up_d     = dir_up_q;
`endif
        led_d        = led_q;
        tick_d       = '0;

        for (int i = 0; i < CH_NUM; i++) begin
            if (cfg_hit[i]) begin
                // A config write restarts the channel from a known dark phase.
                mode_d[i]   = mode_e'(cfg_mode);
                half_d[i]   = cfg_half;
                duty_d[i]   = cfg_duty;
`ifdef LED_BREATHE_EN
                dir_up_d[i] = 1'b1;
`endif
                cnt_d[i]    = '0;
                led_d[i]    = 1'b0;
            end else if (!en[i] || (sync && mode_q[i] == MODE_BLINK)) begin
                cnt_d[i] = '0;
                led_d[i] = 1'b0;
            end else begin
                case (mode_q[i])
                    MODE_OFF: begin
                        cnt_d[i] = '0;
                        led_d[i] = 1'b0;
                    end
                    MODE_ON: begin
                        cnt_d[i] = '0;
                        led_d[i] = 1'b1;
                    end
                    MODE_BLINK: begin
                        if (cnt_q[i] == half_q[i]) begin
                            cnt_d[i]  = '0;
                            led_d[i]  = ~led_q[i];
                            tick_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    MODE_PWM: begin
                        led_d[i]  = (pwm_cnt_q < duty_q[i]);
                        tick_d[i] = (pwm_cnt_q == PWM_MAX);
`ifdef LED_BREATHE_EN
                        // At each half-period expiry the duty takes one step
                        // along the triangle, and the direction turns at either end.
                        if (cnt_q[i] == half_q[i]) begin
                            cnt_d[i] = '0;
                            if (dir_up_q[i]) begin
                                if (duty_q[i] == PWM_MAX) begin
                                    dir_up_d[i] = 1'b0;
                                    duty_d[i]   = duty_q[i] - PWM_W'(1);
                                end else begin
                                    duty_d[i]   = duty_q[i] + PWM_W'(1);
                                end
                            end else if (duty_q[i] == '0) begin
                                dir_up_d[i] = 1'b1;
                                duty_d[i]   = duty_q[i] + PWM_W'(1);
                            end else begin
                                duty_d[i]   = duty_q[i] - PWM_W'(1);
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
`else
                        cnt_d[i] = '0;
`endif
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q    <= '0;
            ready_pipe_q <= 1'b0;
            cfg_ready_q  <= 1'b0;
            led_q        <= '0;
            tick_q       <= '0;
            // NOTE: the per-channel arrays are small flop banks, not RAM, so they are reset to defined defaults.
            for (int i = 0; i < CH_NUM; i++) begin
                mode_q[i]   <= MODE_BLINK;
                half_q[i]   <= DEF_HALF;
                duty_q[i]   <= DUTY_RST;
                cnt_q[i]    <= '0;
`ifdef LED_BREATHE_EN
                dir_up_q[i] <= 1'b1;
`endif
            end
        end else begin
            // NOTE: non-blocking assignments so that every flop samples the pre-edge values.
            pwm_cnt_q    <= pwm_cnt_d;
            ready_pipe_q <= ready_pipe_d;
            cfg_ready_q  <= cfg_ready_d;
            led_q        <= led_d;
            tick_q       <= tick_d;
            mode_q       <= mode_d;
            half_q       <= half_d;
            duty_q       <= duty_d;
            cnt_q        <= cnt_d;
`ifdef LED_BREATHE_EN
            dir_up_q     <= dir_up_d;
`endif
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign led       = led_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_led_blink_array.sv
// -----------------------------------------------------------------------------
// tb_led_blink_array
//   Self-checking bench for led_blink_array (CH_NUM=4, CH_W=3, DEF_HALF=3).
//   The reference model describes each channel by the number of edges since
//   it was last cleared. From that number the blink level and tick follow by
//   division and modulo, and the PWM level follows from a free-running
//   position inside the PWM period.
// -----------------------------------------------------------------------------
module tb_led_blink_array;

    localparam int CH_NUM = 4;
    localparam int CH_W   = 3;
    localparam int CNT_W  = 27;
    localparam int PWM_W  = 8;
    localparam int PWM_P  = 256;
    localparam logic [CNT_W-1:0] DEF_HALF = 27'd3;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH_NUM-1:0] en;
    logic              sync;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [1:0]        cfg_mode;
    logic [CNT_W-1:0]  cfg_half;
    logic [PWM_W-1:0]  cfg_duty;
    logic [CH_NUM-1:0] led;
    logic [CH_NUM-1:0] tick;

    led_blink_array #(
        .CH_NUM  (CH_NUM),
        .CH_W    (CH_W),
        .CNT_W   (CNT_W),
        .PWM_W   (PWM_W),
        .DEF_HALF(DEF_HALF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_half (cfg_half),
        .cfg_duty (cfg_duty),
        .led      (led),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int     m_mode [CH_NUM];
    longint m_half [CH_NUM];
    int     m_duty [CH_NUM];
    bit     m_up   [CH_NUM];
    longint m_age  [CH_NUM];   // edges since the channel was last cleared
    bit     m_led  [CH_NUM];
    bit     m_tick [CH_NUM];
    int     m_pwm;             // position inside the PWM period
    int     m_rst_seen;        // edges since reset was released (saturating)

    task automatic model_edge();
        bit acc;
        if (rst) begin
            for (int c = 0; c < CH_NUM; c++) begin
                m_mode[c] = 2; m_half[c] = longint'(DEF_HALF); m_duty[c] = PWM_P / 2;
                m_up[c] = 1'b1; m_age[c] = 0; m_led[c] = 1'b0; m_tick[c] = 1'b0;
            end
            m_pwm = 0;
            m_rst_seen = 0;
            return;
        end
        acc = cfg_valid && (m_rst_seen >= 2);
        for (int c = 0; c < CH_NUM; c++) begin
            m_tick[c] = 1'b0;
            if (acc && int'(cfg_ch) == c) begin
                m_mode[c] = int'(cfg_mode); m_half[c] = longint'(cfg_half);
                m_duty[c] = int'(cfg_duty); m_up[c] = 1'b1;
                m_age[c] = 0; m_led[c] = 1'b0;
            end else if (!en[c] || (sync && m_mode[c] == 2)) begin
                m_age[c] = 0; m_led[c] = 1'b0;
            end else if (m_mode[c] == 0 || m_mode[c] == 1) begin
                m_age[c] = 0; m_led[c] = (m_mode[c] == 1);
            end else if (m_mode[c] == 2) begin
                m_age[c]++;
                m_led[c]  = ((m_age[c] / (m_half[c] + 1)) % 2) == 1;
                m_tick[c] = (m_age[c] % (m_half[c] + 1)) == 0;
            end else begin
                m_led[c]  = m_pwm < m_duty[c];
                m_tick[c] = (m_pwm == PWM_P - 1);
`ifdef LED_BREATHE_EN
                m_age[c]++;
                if (m_age[c] % (m_half[c] + 1) == 0) begin
                    if (m_up[c] && m_duty[c] == PWM_P - 1) m_up[c] = 1'b0;
                    else if (!m_up[c] && m_duty[c] == 0)   m_up[c] = 1'b1;
                    m_duty[c] += m_up[c] ? 1 : -1;
                end
`endif
            end
        end
        m_pwm = (m_pwm + 1) % PWM_P;
        if (m_rst_seen < 2) m_rst_seen++;
    endtask

    // One clock: the model advances with the DUT edge, and the outputs are compared #1 later.
    task automatic cycle();
        logic [CH_NUM-1:0] e_led, e_tick;
        @(posedge clk);
        model_edge();
        #1;
        for (int c = 0; c < CH_NUM; c++) begin
            e_led[c]  = m_led[c];
            e_tick[c] = m_tick[c];
        end
        check("led", 32'(led), 32'(e_led));
        check("tick", 32'(tick), 32'(e_tick));
        check("cfg_ready", 32'(cfg_ready), 32'(m_rst_seen >= 2));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic cfg_write(input int ch, input int mode, input int half, input int duty);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_mode  = 2'(mode);
        cfg_half  = CNT_W'(half);
        cfg_duty  = PWM_W'(duty);
        cycle();
        cfg_valid = 1'b0;
    endtask

    int high_cnt;
    int r, k;

    initial begin
        rst = 1'b1; en = '1; sync = 1'b0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_mode = '0; cfg_half = '0; cfg_duty = '0;

        // 1: defaults after reset, where all channels blink with a period of 8 clocks
        run(2);
        rst = 1'b0;
        run(20);

        // 2: ch2 half=1
        cfg_write(2, 2, 1, 0);
        run(16);

        // 3: ch1 PWM duty 64, then duty 0
        cfg_write(1, 3, 0, 64);
        run(300);
`ifndef LED_BREATHE_EN
        high_cnt = 0;
        for (int i = 0; i < PWM_P; i++) begin
            cycle();
            high_cnt += int'(led[1]);
        end
        check("pwm_high_64", 32'(high_cnt), 32'd64);
`endif
        cfg_write(1, 3, 0, 0);
        high_cnt = 0;
        for (int i = 0; i < PWM_P; i++) begin
            cycle();
            high_cnt += int'(led[1]);
        end
`ifndef LED_BREATHE_EN
        check("pwm_high_0", 32'(high_cnt), 32'd0);
`endif

        // 4: OFF, ON, then a write to an out-of-range channel
        cfg_write(1, 0, 0, 0);
        run(5);
        cfg_write(1, 1, 0, 0);
        run(5);
        cfg_write(7, 0, 0, 0);
        run(5);

        // 5: disable ch0, sync mid-blink, reset mid-blink
        en[0] = 1'b0;
        run(10);
        en[0] = 1'b1;
        run(5);
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        run(6);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(12);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 39) == 0) begin
                k = $urandom_range(0, CH_NUM - 1);
                en[k] = ~en[k];
            end
            sync      = ($urandom_range(0, 29) == 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_ch    = CH_W'($urandom_range(0, 7));
            cfg_mode  = 2'($urandom_range(0, 3));
            cfg_half  = CNT_W'($urandom_range(0, 5));
            r = $urandom_range(0, 3);
            cfg_duty  = (r == 0) ? 8'h00 : (r == 1) ? 8'hff : PWM_W'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
